div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Divider handshake bundle: request side (start/operands/cancel) and
// result side (stall/done/quotient/remainder/div_zero).
interface div_unit_if;
  logic        start;
  logic        signed_div;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        cancel;
  logic        stall_req;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  modport master (
    output start, signed_div, operand_1, operand_2, cancel,
    input  stall_req, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, signed_div, operand_1, operand_2, cancel,
    output stall_req, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with pipeline stall,
// cancel and divide-by-zero handling. 32 iterations per non-zero divide.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] dividend;     // shifts left; quotient bits enter at the bottom
  logic [31:0] divisor;
  logic [31:0] partial;      // running remainder magnitude
  logic        neg_quo;
  logic        neg_rem;
  logic [31:0] result_quo;
  logic [31:0] result_rem;
  logic        zero_flag;
  logic        done_flag;

  logic        neg_1;
  logic        neg_2;
  logic [31:0] mag_1;
  logic [31:0] mag_2;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] partial_step;
  logic [31:0] dividend_step;

  // Operand magnitudes; -2^31 maps to 0x80000000, which is exact as unsigned.
  always_comb begin
    neg_1 = bus.signed_div & bus.operand_1[31];
    neg_2 = bus.signed_div & bus.operand_2[31];
    mag_1 = neg_1 ? (~bus.operand_1 + 32'd1) : bus.operand_1;
    mag_2 = neg_2 ? (~bus.operand_2 + 32'd1) : bus.operand_2;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The difference is below the divisor, so 32-bit subtraction is exact.
  always_comb begin
    trial         = {partial, dividend[31]};
    fits          = (trial >= {1'b0, divisor});
    partial_step  = fits ? (trial[31:0] - divisor) : trial[31:0];
    dividend_step = {dividend[30:0], fits};
  end

  // Main FSM: operand capture, iteration, result/sign fix-up, cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 5'd0;
      dividend   <= 32'd0;
      divisor    <= 32'd0;
      partial    <= 32'd0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      result_quo <= 32'd0;
      result_rem <= 32'd0;
      zero_flag  <= 1'b0;
      done_flag  <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      if (bus.cancel) begin
        // Abort: results keep their previous values, no done pulse.
        state <= IDLE;
        count <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              dividend <= mag_1;
              divisor  <= mag_2;
              partial  <= 32'd0;
              neg_quo  <= neg_1 ^ neg_2;
              neg_rem  <= neg_1;
              count    <= 5'd0;
              if (bus.operand_2 == 32'd0) begin
                result_quo <= 32'hFFFF_FFFF;
                result_rem <= bus.operand_1;
                zero_flag  <= 1'b1;
                done_flag  <= 1'b1;
                state      <= DONE;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            dividend <= dividend_step;
            partial  <= partial_step;
            count    <= count + 5'd1;
            if (count == 5'd31) begin
              result_quo <= neg_quo ? (~dividend_step + 32'd1) : dividend_step;
              result_rem <= neg_rem ? (~partial_step + 32'd1) : partial_step;
              zero_flag  <= 1'b0;
              done_flag  <= 1'b1;
              state      <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Stall is combinational so the issuing instruction holds in its own cycle.
  always_comb begin
    bus.stall_req = ~rst & (((state == IDLE) & bus.start & ~bus.cancel) | (state == CALC));
  end

  assign bus.done      = done_flag;
  assign bus.quotient  = result_quo;
  assign bus.remainder = result_rem;
  assign bus.div_zero  = zero_flag;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: behavioural reference model plus
// directed literal cases and randomized divides with cancel/extra starts.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int dut_dones = 0;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } res_t;

  // Reference result from plain integer arithmetic.
  function automatic res_t ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    res_t   res;
    longint la, lb, lq, lr;
    if (b == 32'd0) begin
      res.q  = 32'hFFFF_FFFF;
      res.r  = a;
      res.dz = 1'b1;
    end else begin
      if (s) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
      end
      lq = la / lb;
      lr = la % lb;
      res.q  = lq[31:0];
      res.r  = lr[31:0];
      res.dz = 1'b0;
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 busy (countdown of remaining edges), 2 done.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_q     = 32'd0;
  logic [31:0] m_r     = 32'd0;
  logic        m_dz    = 1'b0;
  logic        m_done  = 1'b0;
  res_t        m_pend;

  // Model state advance on each edge / reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_q     <= 32'd0;
      m_r     <= 32'd0;
      m_dz    <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (bus.cancel) begin
        m_phase <= 0;
      end else if (m_phase == 0) begin
        if (bus.start) begin
          if (bus.operand_2 == 32'd0) begin
            m_q     <= 32'hFFFF_FFFF;
            m_r     <= bus.operand_1;
            m_dz    <= 1'b1;
            m_done  <= 1'b1;
            m_phase <= 2;
          end else begin
            m_pend  <= ref_div(bus.signed_div, bus.operand_1, bus.operand_2);
            m_left  <= 32;
            m_phase <= 1;
          end
        end
      end else if (m_phase == 1) begin
        if (m_left == 1) begin
          m_q     <= m_pend.q;
          m_r     <= m_pend.r;
          m_dz    <= m_pend.dz;
          m_done  <= 1'b1;
          m_phase <= 2;
        end else begin
          m_left <= m_left - 1;
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = !rst && (((m_phase == 0) && bus.start && !bus.cancel) || (m_phase == 1));
    check("done",      {31'd0, bus.done},      {31'd0, m_done});
    check("stall_req", {31'd0, bus.stall_req}, {31'd0, exp_stall});
    check("quotient",  bus.quotient,           m_q);
    check("remainder", bus.remainder,          m_r);
    check("div_zero",  {31'd0, bus.div_zero},  {31'd0, m_dz});
    if (bus.done) dut_dones++;
  end

  // Issue one divide (entered/left #1 after an edge, DUT idle) and wait for done.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic chk, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz);
    int n;
    int stalls;
    bus.start      = 1'b1;
    bus.signed_div = s;
    bus.operand_1  = a;
    bus.operand_2  = b;
    #1;
    stalls = bus.stall_req ? 1 : 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 60) begin
      if (bus.stall_req) stalls++;
      @(posedge clk); #1;
      n++;
    end
    $display("op signed=%0d %h / %h -> q=%h r=%h dz=%0d latency=%0d stalls=%0d",
             s, a, b, bus.quotient, bus.remainder, bus.div_zero, n, stalls);
    if (chk) begin
      check("latency",      n,      (b == 32'd0) ? 32'd0 : 32'd32);
      check("stall_cycles", stalls, (b == 32'd0) ? 32'd1 : 32'd33);
      check("lit_quotient",  bus.quotient,  eq);
      check("lit_remainder", bus.remainder, er);
      check("lit_div_zero",  {31'd0, bus.div_zero}, {31'd0, edz});
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d0;
    int n;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.operand_1  = 32'd0;
    bus.operand_2  = 32'd0;
    bus.cancel     = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_quotient",  bus.quotient,  32'd0);
    check("reset_remainder", bus.remainder, 32'd0);
    check("reset_div_zero",  {31'd0, bus.div_zero},  32'd0);
    check("reset_done",      {31'd0, bus.done},      32'd0);
    check("reset_stall",     {31'd0, bus.stall_req}, 32'd0);

    // Directed cases with hand-computed results.
    do_op(1'b0, 32'd100,        32'd7,          1'b1, 32'd14,        32'd2,         1'b0);
    do_op(1'b1, 32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b1, 32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0);
    do_op(1'b0, 32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    do_op(1'b1, 32'h8765_4321,  32'd0,          1'b1, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1);
    do_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,         1'b0);
    do_op(1'b0, 32'hFFFF_FFFF,  32'd1,          1'b1, 32'hFFFF_FFFF, 32'd0,         1'b0);

    // Cancel at iteration 10, then restart the following cycle.
    d0 = dut_dones;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.operand_1 = 32'd1000; bus.operand_2 = 32'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.cancel = 1'b1;
    #1 check("cancel_stall_in_calc", {31'd0, bus.stall_req}, 32'd1);
    @(posedge clk); #1 bus.cancel = 1'b0;
    check("cancel_idle_stall", {31'd0, bus.stall_req}, 32'd0);
    check("cancel_no_done",    dut_dones - d0,         32'd0);
    check("cancel_keep_q",     bus.quotient,           32'hFFFF_FFFF);
    check("cancel_keep_r",     bus.remainder,          32'd0);
    $display("cancel issued at iteration 10, restarting");
    do_op(1'b0, 32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0);

    // Reset pulse mid-CALC discards the operation.
    d0 = dut_dones;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.operand_1 = 32'h1234_5678; bus.operand_2 = 32'h100;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_quotient",  bus.quotient,  32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_stall",     {31'd0, bus.stall_req}, 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("rst_no_done", dut_dones - d0, 32'd0);
    $display("reset mid-calc, no done afterwards");

    // Extra start during CALC is ignored: exactly one done.
    d0 = dut_dones;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.operand_1 = 32'h0BAD_F00D; bus.operand_2 = 32'h1234;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b1; bus.operand_1 = 32'd5; bus.operand_2 = 32'd5;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("extra_start_one_done", dut_dones - d0, 32'd1);
    check("extra_start_q", bus.quotient,  32'd42049);
    check("extra_start_r", bus.remainder, 32'd217);
    $display("extra start ignored: q=%h r=%h", bus.quotient, bus.remainder);

    // Randomized divides with occasional cancel and stray start pulses.
    for (int i = 0; i < 60; i++) begin
      logic s;
      logic [31:0] a, b;
      int k;
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      bus.start = 1'b1; bus.signed_div = s; bus.operand_1 = a; bus.operand_2 = b;
      @(posedge clk); #1 bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 40) begin
        if ($urandom_range(0, 39) == 0) bus.cancel = 1'b1;
        if ($urandom_range(0, 29) == 0) begin
          bus.start = 1'b1;
          bus.operand_1 = $urandom;
        end
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        n++;
      end
      $display("rand %0d signed=%0d %h / %h -> done=%0d q=%h r=%h dz=%0d",
               i, s, a, b, bus.done, bus.quotient, bus.remainder, bus.div_zero);
      k = 0;
      while ((bus.stall_req || bus.done) && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
